// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin scheduler driving a 4-way 2-bit mux with burst-limited grants
//
// Parameters:
//   HOLD_MAX  maximum transfers per grant (1..255)
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   req[3:0]  request per requester
//   p0..p3    2-bit data word of each requester
//   grant     one-hot current owner, 0 when idle
//   sel       binary index of current or last owner (mux select)
//   sout      registered selected word
//   sout_vld  sout carries a transferred word this cycle
//   busy      a grant is active (OR of grant)
module mux4_rr_sched #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [1:0] p0,
    input  logic [1:0] p1,
    input  logic [1:0] p2,
    input  logic [1:0] p3,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [1:0] sout,
    output logic       sout_vld,
    output logic       busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] sel_nxt;
    logic [1:0] sout_nxt;
    logic       vld_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] cnt, cnt_nxt;

    logic [1:0] pick_base;
    logic [1:0] pick_idx;
    logic       pick_ok;
    logic [1:0] owner_data;

    // From IDLE the scan starts at ptr; on release inside BUSY it starts
    // just past the current owner, which is what ptr is about to become.
    assign pick_base = (state == IDLE) ? ptr : sel + 2'd1;

    // Scan offsets from highest to lowest so the nearest requester to
    // pick_base is the last one written and therefore wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = pick_base;
        for (int k = 3; k >= 0; k--) begin
            if (req[pick_base + 2'(k)]) begin
                pick_ok  = 1'b1;
                pick_idx = pick_base + 2'(k);
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    owner_data = p0;
            2'd1:    owner_data = p1;
            2'd2:    owner_data = p2;
            default: owner_data = p3;
        endcase
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        sout_nxt  = sout;
        vld_nxt   = 1'b0;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    grant_nxt = 4'b0001 << pick_idx;
                    sel_nxt   = pick_idx;
                    cnt_nxt   = 8'd0;
                    state_nxt = BUSY;
                end
            end
            default: begin
                if (req[sel]) begin
                    sout_nxt = owner_data;
                    vld_nxt  = 1'b1;
                    cnt_nxt  = cnt + 8'd1;
                end
                // Release happens on the last word of a burst or when the
                // owner drops its request; re-arbitrate in the same edge.
                if (!req[sel] || cnt == LAST) begin
                    ptr_nxt = sel + 2'd1;
                    if (pick_ok) begin
                        grant_nxt = 4'b0001 << pick_idx;
                        sel_nxt   = pick_idx;
                        cnt_nxt   = 8'd0;
                    end else begin
                        grant_nxt = 4'b0000;
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            sel      <= 2'd0;
            sout     <= 2'd0;
            sout_vld <= 1'b0;
            ptr      <= 2'd0;
            cnt      <= 8'd0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            sout     <= sout_nxt;
            sout_vld <= vld_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb/tb_mux4_rr_sched.sv - directed scoreboard bench for mux4_rr_sched (HOLD_MAX 4 and 1)
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] p0 = 2'd0, p1 = 2'd0, p2 = 2'd0, p3 = 2'd0;

    logic [3:0] a_grant, b_grant;
    logic [1:0] a_sel, b_sel, a_sout, b_sout;
    logic       a_vld, b_vld, a_busy, b_busy;

    mux4_rr_sched #(.HOLD_MAX(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3),
        .grant(a_grant), .sel(a_sel), .sout(a_sout), .sout_vld(a_vld), .busy(a_busy)
    );

    mux4_rr_sched #(.HOLD_MAX(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3),
        .grant(b_grant), .sel(b_sel), .sout(b_sout), .sout_vld(b_vld), .busy(b_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic [1:0] o;
        logic       v;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic use_b = 1'b0;

    function automatic exp_t observed();
        if (use_b) return {b_grant, b_sel, b_sout, b_vld, b_busy};
        return {a_grant, a_sel, a_sout, a_vld, a_busy};
    endfunction

    task automatic push(input logic [3:0] g, input logic [1:0] s,
                        input logic [1:0] o, input logic v);
        exp_t e;
        e = {g, s, o, v, (g != 4'b0000)};
        q.push_back(e);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        exp_t o;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            o = observed();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed g=%b s=%0d o=%0d v=%b b=%b expected g=%b s=%0d o=%0d v=%b b=%b",
                       tag, o.g, o.s, o.o, o.v, o.b, e.g, e.s, e.o, e.v, e.b);
            end
        end
    endtask

    task automatic step(input logic [3:0] g, input logic [1:0] s,
                        input logic [1:0] o, input logic v, input string tag);
        push(g, s, o, v);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    initial begin
        logic [1:0] idx;

        // Reset with random inputs
        rst_n = 1'b0;
        req = 4'($urandom);
        p0 = 2'($urandom); p1 = 2'($urandom); p2 = 2'($urandom); p3 = 2'($urandom);
        repeat (3) @(posedge clk);
        #1;
        push(4'b0000, 2'd0, 2'd0, 1'b0);
        check_now("reset");

        // Single requester: continuous words, re-grant every 4 words
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0001;
        p0 = 2'b10;
        step(4'b0001, 2'd0, 2'd0, 1'b0, "single_grant");
        for (int k = 1; k <= 8; k++)
            step(4'b0001, 2'd0, 2'b10, 1'b1, "single_data");

        // Asynchronous reset in the middle of a burst
        #2;
        rst_n = 1'b0;
        #1;
        push(4'b0000, 2'd0, 2'd0, 1'b0);
        check_now("async_rst");
        req = 4'b0000;

        // Full contention: each owner held for 4 words in rotation
        @(negedge clk);
        rst_n = 1'b1;
        p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; p3 = 2'd3;
        req = 4'b1111;
        step(4'b0001, 2'd0, 2'd0, 1'b0, "full_grant");
        for (int k = 1; k <= 17; k++) begin
            idx = 2'((k / 4) % 4);
            step(4'b0001 << idx, idx, 2'(((k - 1) / 4) % 4), 1'b1, "full_rr");
        end

        // Early drop by owner 2, then priority wrap from owner 3
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1100;
        step(4'b0100, 2'd2, 2'd0, 1'b0, "drop_grant");
        step(4'b0100, 2'd2, 2'b10, 1'b1, "drop_w1");
        step(4'b0100, 2'd2, 2'b10, 1'b1, "drop_w2");
        req = 4'b1000;
        step(4'b1000, 2'd3, 2'b10, 1'b0, "drop_gap");
        step(4'b1000, 2'd3, 2'b11, 1'b1, "drop_p3");
        req = 4'b0011;
        step(4'b0001, 2'd0, 2'b11, 1'b0, "wrap_grant");
        step(4'b0001, 2'd0, 2'b00, 1'b1, "wrap_data");

        // HOLD_MAX=1: owners 0 and 2 alternate every word
        rst_n = 1'b0;
        #1;
        use_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        p0 = 2'b01; p2 = 2'b10;
        req = 4'b0101;
        step(4'b0001, 2'd0, 2'd0, 1'b0, "h1_grant");
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 1) step(4'b0100, 2'd2, 2'b01, 1'b1, "h1_alt");
            else            step(4'b0001, 2'd0, 2'b10, 1'b1, "h1_alt");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
